bcd_2421_to_8421_seq: RTL and testbench

BCD_2421_TO_8421_SEQ -- requirements
Module: bcd_2421_to_8421_seq

---
 rtl/bcd_2421_to_8421_seq.sv | 155 +++++++++++++++
 tb/tb_bcd_2421_to_8421_seq.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_2421_to_8421_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : bcd_2421_to_8421_seq                                            |
// | Desc   : Serial 2421->8421 BCD and binary converter, one digit per cycle |
// |          behind a valid/ready handshake. BCD2421_ERRCHK_EN enables        |
// |          invalid-code flagging.                                          |
// | Rev    : 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module bcd_2421_to_8421_seq #(
   parameter int NDIG = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4*NDIG-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [4*NDIG-1:0] out_bcd,
   output logic [4*NDIG-1:0] out_bin,
   output logic              out_err
);

   localparam int         W        = 4 * NDIG;
   localparam logic [3:0] IDX_LAST = 4'(NDIG - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t       r_state;
   state_t       w_state_next;

   logic [W-1:0] r_word;
   logic [W-1:0] r_acc;
   logic [W-1:0] r_bcd;
   logic [W-1:0] r_out_bcd;
   logic [W-1:0] r_out_bin;
   logic [3:0]   r_idx;

   logic [3:0]   w_code;
   logic [3:0]   w_digit;
   logic [3:0]   w_nib;
   logic         w_last;
   logic         w_accept;
   logic [W-1:0] w_acc_next;
   logic [W-1:0] w_bcd_next;
   logic [W-1:0] w_bin_result;

   // Current digit is always the top nibble; the word shifts left as it is consumed.
   assign w_code     = r_word[W-1 -: 4];
   assign w_digit    = w_code[3] ? (w_code - 4'd6) : w_code;
   assign w_last     = (r_idx == IDX_LAST);
   assign w_accept   = in_ready && in_valid;
   assign w_acc_next = (r_acc << 3) + (r_acc << 1) + W'(w_digit);
   assign w_bcd_next = (r_bcd << 4) | W'(w_nib);

`ifdef BCD2421_ERRCHK_EN
   logic r_err;
   logic r_out_err;
   logic w_code_bad;
   logic w_err_any;

   assign w_code_bad   = (w_code >= 4'd5) && (w_code <= 4'd10);
   assign w_err_any    = r_err | w_code_bad;
   assign w_nib        = w_code_bad ? 4'hF : w_digit;
   assign w_bin_result = w_err_any ? '0 : w_acc_next;
   assign out_err      = r_out_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err     <= 1'b0;
         r_out_err <= 1'b0;
      end else if (w_accept) begin
         r_err <= 1'b0;
      end else if (r_state == CONV) begin
         r_err <= w_err_any;
         if (w_last) begin
            r_out_err <= w_err_any;
         end
      end
   end
`else
   assign w_nib        = w_digit;
   assign w_bin_result = w_acc_next;
   assign out_err      = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_state_next = CONV;
            end
         end
         CONV: begin
            if (w_last) begin
               w_state_next = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Result registers load only on the final digit so no partial value is ever visible.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_word    <= '0;
         r_acc     <= '0;
         r_bcd     <= '0;
         r_idx     <= '0;
         r_out_bcd <= '0;
         r_out_bin <= '0;
      end else if (w_accept) begin
         r_word <= in_data;
         r_acc  <= '0;
         r_bcd  <= '0;
         r_idx  <= '0;
      end else if (r_state == CONV) begin
         r_word <= r_word << 4;
         r_acc  <= w_acc_next;
         r_bcd  <= w_bcd_next;
         r_idx  <= r_idx + 4'd1;
         if (w_last) begin
            r_out_bcd <= w_bcd_next;
            r_out_bin <= w_bin_result;
         end
      end
   end

   assign out_bcd = r_out_bcd;
   assign out_bin = r_out_bin;

endmodule
`default_nettype wire

// File: tb/tb_bcd_2421_to_8421_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_bcd_2421_to_8421_seq                                         |
// | Desc   : Directed self-checking bench for bcd_2421_to_8421_seq, NDIG=4.  |
// | Rev    : 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module tb_bcd_2421_to_8421_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_bcd;
   logic [15:0] out_bin;
   logic        out_err;

   int checks = 0;
   int errors = 0;

   bcd_2421_to_8421_seq #(.NDIG(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_bcd   (out_bcd),
      .out_bin   (out_bin),
      .out_err   (out_err)
   );

   always #5 clk = ~clk;

   // Handshake one word (caller sets out_ready); returns the result and edges to out_valid.
   task automatic run_word(input logic [15:0] d, output logic [15:0] bcd,
                           output logic [15:0] bin, output logic err, output int lat);
      in_valid = 1'b1;
      in_data  = d;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = 16'h5A5A;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      bcd = out_bcd;
      bin = out_bin;
      err = out_err;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_data = 16'h0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_bcd !== 16'h0 ||
          out_bin !== 16'h0 || out_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got v=%b r=%b bcd=%h bin=%h err=%b, want v=0 r=1 bcd=0000 bin=0000 err=0",
                  out_valid, in_ready, out_bcd, out_bin, out_err);
      end
      rst = 1'b0;
   endtask

   task automatic test_nominal();
      int lat;
      bit busy_bad;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 16'hFB0D;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = 16'h0000;
      lat = 0;
      busy_bad = 1'b0;
      while (!out_valid && lat < 20) begin
         if (in_ready !== 1'b0) busy_bad = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if (lat !== 4) begin
         errors++;
         $display("FAIL nominal_latency: got %0d, want 4", lat);
      end
      checks++;
      if (busy_bad) begin
         errors++;
         $display("FAIL nominal_busy_ready: in_ready got 1 during CONV, want 0");
      end
      checks++;
      if (out_bcd !== 16'h9507 || out_bin !== 16'h2523 || out_err !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL nominal_result: got bcd=%h bin=%h err=%b r=%b, want 9507 2523 0 0",
                  out_bcd, out_bin, out_err, in_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_bcd !== 16'h9507) begin
         errors++;
         $display("FAIL nominal_release: got v=%b r=%b bcd=%h, want 0 1 9507", out_valid, in_ready, out_bcd);
      end
   endtask

   task automatic test_patterns();
      logic [15:0] vin  [5] = '{16'hFFFF, 16'h0000, 16'h0123, 16'h4BCD, 16'hEF00};
      logic [15:0] vbcd [5] = '{16'h9999, 16'h0000, 16'h0123, 16'h4567, 16'h8900};
      logic [15:0] vbin [5] = '{16'h270F, 16'h0000, 16'h007B, 16'h11D7, 16'h22C4};
      logic [15:0] bcd, bin;
      logic err;
      int lat;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         run_word(vin[i], bcd, bin, err, lat);
         checks++;
         if (bcd !== vbcd[i] || bin !== vbin[i] || err !== 1'b0 || lat !== 4) begin
            errors++;
            $display("FAIL pattern_%h: got bcd=%h bin=%h err=%b lat=%0d, want %h %h 0 4",
                     vin[i], bcd, bin, err, lat, vbcd[i], vbin[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_invalid();
      logic [15:0] bcd, bin, ebcd, ebin;
      logic err, eerr;
      int lat;
`ifdef BCD2421_ERRCHK_EN
      ebcd = 16'h1F34; ebin = 16'h0000; eerr = 1'b1;
`else
      ebcd = 16'h1434; ebin = 16'h059A; eerr = 1'b0;
`endif
      out_ready = 1'b1;
      run_word(16'h1A34, bcd, bin, err, lat);
      checks++;
      if (bcd !== ebcd || bin !== ebin || err !== eerr) begin
         errors++;
         $display("FAIL invalid_digit: got bcd=%h bin=%h err=%b, want %h %h %b",
                  bcd, bin, err, ebcd, ebin, eerr);
      end
      @(posedge clk); #1;
      run_word(16'h0D0B, bcd, bin, err, lat);
      checks++;
      if (bcd !== 16'h0705 || bin !== 16'h02C1 || err !== 1'b0) begin
         errors++;
         $display("FAIL invalid_clears: got bcd=%h bin=%h err=%b, want 0705 02c1 0", bcd, bin, err);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      logic [15:0] bcd, bin;
      logic err;
      int lat;
      out_ready = 1'b0;
      run_word(16'h0D0B, bcd, bin, err, lat);
      in_valid = 1'b1;
      in_data  = 16'hFFFF;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_bcd !== 16'h0705 || out_bin !== 16'h02C1) begin
            errors++;
            $display("FAIL backpressure_hold_%0d: got v=%b r=%b bcd=%h bin=%h, want 1 0 0705 02c1",
                     i, out_valid, in_ready, out_bcd, out_bin);
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_bcd !== 16'h0705) begin
         errors++;
         $display("FAIL backpressure_release: got v=%b r=%b bcd=%h, want 0 1 0705", out_valid, in_ready, out_bcd);
      end
      run_word(16'hFFFF, bcd, bin, err, lat);
      checks++;
      if (bcd !== 16'h9999 || bin !== 16'h270F || lat !== 4) begin
         errors++;
         $display("FAIL backpressure_next: got bcd=%h bin=%h lat=%0d, want 9999 270f 4", bcd, bin, lat);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      logic [15:0] bcd, bin;
      logic err;
      int lat;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 16'hFBCD;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_bcd !== 16'h0 ||
          out_bin !== 16'h0 || out_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: got v=%b r=%b bcd=%h bin=%h err=%b, want 0 1 0000 0000 0",
                  out_valid, in_ready, out_bcd, out_bin, out_err);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      run_word(16'h2B3C, bcd, bin, err, lat);
      checks++;
      if (bcd !== 16'h2536 || bin !== 16'h09E8 || lat !== 4) begin
         errors++;
         $display("FAIL reset_mid_next: got bcd=%h bin=%h lat=%0d, want 2536 09e8 4", bcd, bin, lat);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int t [2];
      logic [15:0] rb [2];
      logic [15:0] rn [2];
      int n = 0;
      int cyc = 0;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 16'h2B3C;
      @(posedge clk); #1;
      in_data = 16'h4F1E;
      while (n < 2 && cyc < 30) begin
         @(posedge clk); #1;
         cyc++;
         if (out_valid) begin
            t[n]  = cyc;
            rb[n] = out_bcd;
            rn[n] = out_bin;
            n++;
            if (n == 2) in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      checks++;
      if (n !== 2) begin
         errors++;
         $display("FAIL b2b_count: got %0d results, want 2", n);
      end else begin
         checks++;
         if (rb[0] !== 16'h2536 || rn[0] !== 16'h09E8 || rb[1] !== 16'h4918 || rn[1] !== 16'h1336) begin
            errors++;
            $display("FAIL b2b_order: got %h/%h then %h/%h, want 2536/09e8 then 4918/1336",
                     rb[0], rn[0], rb[1], rn[1]);
         end
         checks++;
         if (t[0] !== 4 || (t[1] - t[0]) !== 6) begin
            errors++;
            $display("FAIL b2b_spacing: got first=%0d gap=%0d, want 4 6", t[0], t[1] - t[0]);
         end
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_patterns();
      test_invalid();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
